ctrl_decode_stage: RTL and testbench
====================================

Name: ctrl_decode_stage

Overview:
- Registered RV32I control decoder sitting between the IF/ID register and the execute stage; successor to the single-cycle main decoder.
- Decodes all RV32I opcodes, not just the load/store/ALU/branch/JAL subset, into a control bundle. Flags illegal encodings.
- Holds the bundle, with PC and instruction, in one pipeline register with a valid/ready handshake, stall and flush.
- Branch resolution moves to execute: this block emits a one-hot branch type and takes no Zero input.

Parameters:
- XLEN, 32, width of pc pass-through.
- SUPPORT_SYSTEM, 1, 1 = ECALL/EBREAK/FENCE decode as legal no-ops; 0 = SYSTEM/MISC-MEM flagged illegal.
- BYPASS, 0, 1 = outputs are combinational from inputs (register removed, handshake passes straight through).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- in_valid  in  1  instruction present.
- in_ready  out  1  stage can accept.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- flush  in  1  kill held and incoming instruction.
- out_valid  out  1  bundle valid.
- out_ready  in  1  execute accepts.
- out_instr  out  32  registered instruction.
- out_pc  out  XLEN  registered PC.
- reg_write  out  1  write rd.
- mem_write  out  1  store.
- mem_read  out  1  load.
- result_src  out  2  00 ALU, 01 mem, 10 PC+4, 11 imm.
- alu_src_a  out  1  0 rs1, 1 PC.
- alu_src_b  out  1  0 rs2, 1 imm.
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- alu_op  out  2  00 add, 01 branch-compare, 10 funct-decoded.
- branch  out  6  one-hot: [0] BEQ, [1] BNE, [2] BLT, [3] BGE, [4] BLTU, [5] BGEU.
- jump  out  1  JAL.
- jalr  out  1  JALR.
- illegal  out  1  unsupported encoding.

Behaviour:
- Decode per opcode:
  - LUI 0110111: RegWrite, ResultSrc=11, U.
  - AUIPC 0010111: RegWrite, SrcA=PC, SrcB=imm, U, add.
  - JAL 1101111: RegWrite, ResultSrc=10, J, jump.
  - JALR 1100111 with funct3=000: RegWrite, ResultSrc=10, SrcB=imm, I, add, jalr.
  - Branch 1100011: B, alu_op=01; branch bit from funct3; funct3 010/011 is illegal.
  - Load 0000011 with funct3 in {000,001,010,100,101}: RegWrite, mem_read, ResultSrc=01, SrcB=imm, I.
  - Store 0100011 with funct3 in {000,001,010}: mem_write, SrcB=imm, S.
  - OP-IMM 0010011: RegWrite, SrcB=imm, I, alu_op=10.
  - OP 0110011: RegWrite, alu_op=10.
  - MISC-MEM 0001111 and SYSTEM 1110011: all controls 0; legal only if SUPPORT_SYSTEM=1.
  - Any other opcode, or in_instr[1:0] != 11: illegal=1.
- Illegal instructions: every side-effect control (reg_write, mem_write, mem_read, branch, jump, jalr) is forced to 0. Still passes with out_valid=1 so the trap logic sees it.
- Branch register is fully assigned every cycle. Exactly zero or one bit is set; no stale bits are held.
- Handshake (BYPASS=0):
  - in_ready = !out_valid || out_ready.
  - Load on in_valid && in_ready.
  - out_valid clears when out_ready && !load.
  - Stall: out_valid && !out_ready holds every output stable.
- Latency: 1 cycle from accept to out_valid. Full throughput with out_ready held high.
- Flush takes priority over load: next cycle out_valid=0. in_ready is unaffected; an instruction offered during flush is dropped.
- Reset (rst=0 at clk edge):
  - out_valid=0.
  - All controls, branch, illegal = 0.
  - out_instr=0x00000013 (NOP), out_pc=0.
  - Reset mid-stall discards the held instruction.
- Control outputs are also zeroed whenever out_valid=0, so downstream may ignore valid for side effects.

Decomposition:
- Package ctrl_pkg holds:
  - Opcode constants.
  - Branch funct3 constants.
  - imm_src, result_src and alu_op encodings.
  - A packed control-bundle typedef.
- Sub-module ctrl_decode_comb: a pure combinational instr→bundle+illegal decoder, reusable by a future dual-issue front end. ctrl_decode_stage wraps it with the pipeline register.

Test Plan:
- Reset: rst=0 two cycles, in_valid=1 → out_valid=0, branch=000000, out_instr=0x00000013.
- BNE 0x00209463 accepted, out_ready=1 → next cycle out_valid=1, branch=000010, imm_src=010, alu_op=01, reg_write=0.
- Back-to-back BEQ then ADD (0x002081B3) → second cycle branch=000000, reg_write=1, alu_op=10; confirms no stale branch bit.
- Stall: LW 0x0000A183 accepted, out_ready=0 for 3 cycles → in_ready=0, outputs hold (result_src=01, mem_read=1); out_ready=1 → next instr loads same edge.
- Flush with valid held and new in_valid → next cycle out_valid=0; dropped instruction never appears.
- Illegal: 0x0000207F and branch funct3=010 → illegal=1, out_valid=1, all side-effect controls 0; ECALL with SUPPORT_SYSTEM=0 → illegal=1, with 1 → illegal=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared RV32I control-decode definitions: opcodes, branch funct3 codes,
// control-field encodings and the packed control bundle.
package ctrl_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int BR_BEQ  = 0;
    localparam int BR_BNE  = 1;
    localparam int BR_BLT  = 2;
    localparam int BR_BGE  = 3;
    localparam int BR_BLTU = 4;
    localparam int BR_BGEU = 5;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } result_src_e;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_FUNCT  = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        mem_read;
        result_src_e result_src;
        logic        alu_src_a;
        logic        alu_src_b;
        imm_src_e    imm_src;
        alu_op_e     alu_op;
        logic [5:0]  branch;
        logic        jump;
        logic        jalr;
    } ctrl_t;

    // Zero for the two reserved funct3 codes; the caller flags those illegal.
    function automatic logic [5:0] branch_onehot(input logic [2:0] funct3);
        logic [5:0] onehot;
        onehot = '0;
        case (funct3)
            F3_BEQ:  onehot[BR_BEQ]  = 1'b1;
            F3_BNE:  onehot[BR_BNE]  = 1'b1;
            F3_BLT:  onehot[BR_BLT]  = 1'b1;
            F3_BGE:  onehot[BR_BGE]  = 1'b1;
            F3_BLTU: onehot[BR_BLTU] = 1'b1;
            F3_BGEU: onehot[BR_BGEU] = 1'b1;
            default: onehot = '0;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure combinational RV32I instruction -> control bundle decoder with an
// illegal-encoding flag. Side-effect controls are suppressed for illegal words.
module ctrl_decode_comb
    import ctrl_pkg::*;
#(
    parameter bit SUPPORT_SYSTEM = 1'b1
) (
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    ctrl_t      raw;
    logic       bad;
    logic       unused_fields;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    // rd/rs1/rs2/funct7 are consumed downstream, not by the control decode.
    assign unused_fields = ^{instr[31:15], instr[11:7]};

    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        raw = '0;
        bad = 1'b0;
        if (instr[1:0] != 2'b11) begin
            bad = 1'b1;
        end else begin
            case (opcode)
                OPC_LUI: begin
                    raw.reg_write  = 1'b1;
                    raw.result_src = RES_IMM;
                    raw.imm_src    = IMM_U;
                end
                OPC_AUIPC: begin
                    raw.reg_write = 1'b1;
                    raw.alu_src_a = 1'b1;
                    raw.alu_src_b = 1'b1;
                    raw.imm_src   = IMM_U;
                    raw.alu_op    = ALU_ADD;
                end
                OPC_JAL: begin
                    raw.reg_write  = 1'b1;
                    raw.result_src = RES_PC4;
                    raw.imm_src    = IMM_J;
                    raw.jump       = 1'b1;
                end
                OPC_JALR: begin
                    raw.reg_write  = 1'b1;
                    raw.result_src = RES_PC4;
                    raw.alu_src_b  = 1'b1;
                    raw.imm_src    = IMM_I;
                    raw.alu_op     = ALU_ADD;
                    raw.jalr       = 1'b1;
                    bad            = (funct3 != 3'b000);
                end
                OPC_BRANCH: begin
                    raw.imm_src = IMM_B;
                    raw.alu_op  = ALU_BRANCH;
                    raw.branch  = branch_onehot(funct3);
                    bad         = (funct3 == 3'b010) || (funct3 == 3'b011);
                end
                OPC_LOAD: begin
                    raw.reg_write  = 1'b1;
                    raw.mem_read   = 1'b1;
                    raw.result_src = RES_MEM;
                    raw.alu_src_b  = 1'b1;
                    raw.imm_src    = IMM_I;
                    bad = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
                end
                OPC_STORE: begin
                    raw.mem_write = 1'b1;
                    raw.alu_src_b = 1'b1;
                    raw.imm_src   = IMM_S;
                    bad           = (funct3 > 3'b010);
                end
                OPC_OP_IMM: begin
                    raw.reg_write = 1'b1;
                    raw.alu_src_b = 1'b1;
                    raw.imm_src   = IMM_I;
                    raw.alu_op    = ALU_FUNCT;
                end
                OPC_OP: begin
                    raw.reg_write = 1'b1;
                    raw.alu_op    = ALU_FUNCT;
                end
                OPC_MISC_MEM, OPC_SYSTEM: begin
                    bad = !SUPPORT_SYSTEM;
                end
                default: bad = 1'b1;
            endcase
        end
    end

    // Illegal words still travel down the pipe for the trap logic, but must
    // not write state or redirect fetch.
    always_comb begin
        ctrl    = raw;
        illegal = bad;
        if (bad) begin
            ctrl.reg_write = 1'b0;
            ctrl.mem_write = 1'b0;
            ctrl.mem_read  = 1'b0;
            ctrl.branch    = '0;
            ctrl.jump      = 1'b0;
            ctrl.jalr      = 1'b0;
        end
    end

endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered RV32I control-decode stage: decodes the IF/ID instruction and
// holds bundle, PC and instruction in one valid/ready pipeline register.
module ctrl_decode_stage
    import ctrl_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter bit SUPPORT_SYSTEM = 1'b1,
    parameter bit BYPASS         = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            reg_write,
    output logic            mem_write,
    output logic            mem_read,
    output logic [1:0]      result_src,
    output logic            alu_src_a,
    output logic            alu_src_b,
    output logic [2:0]      imm_src,
    output logic [1:0]      alu_op,
    output logic [5:0]      branch,
    output logic            jump,
    output logic            jalr,
    output logic            illegal
);

    ctrl_t dec_ctrl;
    logic  dec_illegal;
    ctrl_t out_ctrl;

    ctrl_decode_comb #(
        .SUPPORT_SYSTEM(SUPPORT_SYSTEM)
    ) u_decode (
        .instr  (in_instr),
        .ctrl   (dec_ctrl),
        .illegal(dec_illegal)
    );

    generate
        if (BYPASS) begin : g_bypass
            logic unused_clocking;
            assign unused_clocking = clk ^ rst;

            assign in_ready  = out_ready;
            assign out_valid = in_valid && !flush;
            assign out_instr = in_instr;
            assign out_pc    = in_pc;
            assign out_ctrl  = out_valid ? dec_ctrl : '0;
            assign illegal   = out_valid && dec_illegal;
        end else begin : g_reg
            logic            valid_q,   valid_d;
            ctrl_t           ctrl_q,    ctrl_d;
            logic            illegal_q, illegal_d;
            logic [31:0]     instr_q,   instr_d;
            logic [XLEN-1:0] pc_q,      pc_d;
            logic            load;

            assign in_ready = !valid_q || out_ready;
            assign load     = in_valid && in_ready;

            // The bundle is rewritten on every transition out of valid so no
            // stale branch bit survives into an empty slot.
            always_comb begin
                valid_d   = valid_q;
                ctrl_d    = ctrl_q;
                illegal_d = illegal_q;
                instr_d   = instr_q;
                pc_d      = pc_q;
                if (flush) begin
                    valid_d   = 1'b0;
                    ctrl_d    = '0;
                    illegal_d = 1'b0;
                end else if (load) begin
                    valid_d   = 1'b1;
                    ctrl_d    = dec_ctrl;
                    illegal_d = dec_illegal;
                    instr_d   = in_instr;
                    pc_d      = in_pc;
                end else if (out_ready) begin
                    valid_d   = 1'b0;
                    ctrl_d    = '0;
                    illegal_d = 1'b0;
                end
            end

            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples its pre-edge value regardless of statement order.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    valid_q   <= 1'b0;
                    ctrl_q    <= '0;
                    illegal_q <= 1'b0;
                    instr_q   <= NOP_INSTR;
                    pc_q      <= '0;
                end else begin
                    valid_q   <= valid_d;
                    ctrl_q    <= ctrl_d;
                    illegal_q <= illegal_d;
                    instr_q   <= instr_d;
                    pc_q      <= pc_d;
                end
            end

            assign out_valid = valid_q;
            assign out_instr = instr_q;
            assign out_pc    = pc_q;
            assign out_ctrl  = ctrl_q;
            assign illegal   = illegal_q;
        end
    endgenerate

    assign reg_write  = out_ctrl.reg_write;
    assign mem_write  = out_ctrl.mem_write;
    assign mem_read   = out_ctrl.mem_read;
    assign result_src = out_ctrl.result_src;
    assign alu_src_a  = out_ctrl.alu_src_a;
    assign alu_src_b  = out_ctrl.alu_src_b;
    assign imm_src    = out_ctrl.imm_src;
    assign alu_op     = out_ctrl.alu_op;
    assign branch     = out_ctrl.branch;
    assign jump       = out_ctrl.jump;
    assign jalr       = out_ctrl.jalr;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Scoreboard bench for ctrl_decode_stage: an independent decode model predicts
// each accepted instruction; the queue front is compared while out_valid is high.
module tb_ctrl_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_ready;

    logic        in_ready, out_valid, reg_write, mem_write, mem_read;
    logic        alu_src_a, alu_src_b, jump, jalr, illegal;
    logic [31:0] out_instr, out_pc;
    logic [1:0]  result_src, alu_op;
    logic [2:0]  imm_src;
    logic [5:0]  branch;

    logic        ns_in_ready, ns_out_valid, ns_reg_write, ns_mem_write, ns_mem_read;
    logic        ns_alu_src_a, ns_alu_src_b, ns_jump, ns_jalr, ns_illegal;
    logic [31:0] ns_out_instr, ns_out_pc;
    logic [1:0]  ns_result_src, ns_alu_op;
    logic [2:0]  ns_imm_src;
    logic [5:0]  ns_branch;

    always #5 clk = ~clk;

    ctrl_decode_stage #(.XLEN(32), .SUPPORT_SYSTEM(1'b1), .BYPASS(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .reg_write(reg_write), .mem_write(mem_write), .mem_read(mem_read),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .alu_op(alu_op), .branch(branch),
        .jump(jump), .jalr(jalr), .illegal(illegal)
    );

    ctrl_decode_stage #(.XLEN(32), .SUPPORT_SYSTEM(1'b0), .BYPASS(1'b0)) dut_nosys (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ns_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(ns_out_valid), .out_ready(out_ready),
        .out_instr(ns_out_instr), .out_pc(ns_out_pc),
        .reg_write(ns_reg_write), .mem_write(ns_mem_write), .mem_read(ns_mem_read),
        .result_src(ns_result_src), .alu_src_a(ns_alu_src_a), .alu_src_b(ns_alu_src_b),
        .imm_src(ns_imm_src), .alu_op(ns_alu_op), .branch(ns_branch),
        .jump(ns_jump), .jalr(ns_jalr), .illegal(ns_illegal)
    );

    typedef struct {
        logic        rw, mw, mr, a, b, j, jr, ill, ill_ns;
        logic [1:0]  rs, op;
        logic [2:0]  imm;
        logic [5:0]  br;
        logic [31:0] instr, pc;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   settled = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc, input bit sys);
        exp_t e;
        logic [2:0] f3;
        e = '{default: '0};
        e.instr = ins;
        e.pc    = pc;
        f3 = ins[14:12];
        case (ins[6:0])
            7'h37: begin e.rw = 1; e.rs = 2'b11; e.imm = 3'b100; end
            7'h17: begin e.rw = 1; e.a = 1; e.b = 1; e.imm = 3'b100; end
            7'h6F: begin e.rw = 1; e.rs = 2'b10; e.imm = 3'b011; e.j = 1; end
            7'h67: begin e.rw = 1; e.rs = 2'b10; e.b = 1; e.jr = 1; e.ill = (f3 != 0); end
            7'h63: begin
                e.imm = 3'b010; e.op = 2'b01;
                case (f3)
                    3'd0: e.br = 6'b000001;
                    3'd1: e.br = 6'b000010;
                    3'd4: e.br = 6'b000100;
                    3'd5: e.br = 6'b001000;
                    3'd6: e.br = 6'b010000;
                    3'd7: e.br = 6'b100000;
                    default: e.ill = 1;
                endcase
            end
            7'h03: begin
                e.rw = 1; e.mr = 1; e.rs = 2'b01; e.b = 1;
                e.ill = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
            end
            7'h23: begin e.mw = 1; e.b = 1; e.imm = 3'b001; e.ill = (f3 > 2); end
            7'h13: begin e.rw = 1; e.b = 1; e.op = 2'b10; end
            7'h33: begin e.rw = 1; e.op = 2'b10; end
            7'h0F, 7'h73: e.ill = !sys;
            default: e.ill = 1;
        endcase
        if (ins[1:0] != 2'b11) e.ill = 1;
        if (e.ill) begin
            e.rw = 0; e.mw = 0; e.mr = 0; e.br = '0; e.j = 0; e.jr = 0;
        end
        return e;
    endfunction

    task automatic compare_out(input exp_t e);
        check("reg_write",  reg_write,  e.rw);
        check("mem_write",  mem_write,  e.mw);
        check("mem_read",   mem_read,   e.mr);
        check("result_src", result_src, e.rs);
        check("alu_src_a",  alu_src_a,  e.a);
        check("alu_src_b",  alu_src_b,  e.b);
        check("imm_src",    imm_src,    e.imm);
        check("alu_op",     alu_op,     e.op);
        check("branch",     branch,     e.br);
        check("jump",       jump,       e.j);
        check("jalr",       jalr,       e.jr);
        check("illegal",    illegal,    e.ill);
        check("illegal_nosys", ns_illegal, e.ill_ns);
        check("out_instr",  out_instr,  e.instr);
        check("out_pc",     out_pc,     e.pc);
    endtask

    // One clock: compare current outputs against the scoreboard, update it
    // for this edge's handshake, then advance past the edge.
    task automatic cycle();
        bit   exp_valid;
        exp_t e;
        #1;
        exp_valid = (q.size() != 0);
        if (settled) begin
            check("out_valid", out_valid, exp_valid);
            check("nosys_out_valid", ns_out_valid, exp_valid);
            check("in_ready", in_ready, !exp_valid || out_ready);
            if (exp_valid) begin
                compare_out(q[0]);
            end else begin
                check("idle_side_effects",
                      {reg_write, mem_write, mem_read, branch, jump, jalr, illegal}, '0);
                check("idle_fields", {result_src, alu_src_a, alu_src_b, imm_src, alu_op}, '0);
            end
            if (exp_valid && (out_ready || flush)) void'(q.pop_front());
            if (rst && in_valid && (!exp_valid || out_ready) && !flush) begin
                e = model(in_instr, in_pc, 1'b1);
                e.ill_ns = model(in_instr, in_pc, 1'b0).ill;
                q.push_back(e);
            end
        end
        @(posedge clk);
        if (!rst) begin
            q.delete();
            settled = 1'b1;
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        cycle();
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b1; in_instr = 32'h0020_9463; in_pc = 32'h0;
        flush = 1'b0; out_ready = 1'b1;
        // Reset held two cycles with an instruction offered.
        drive(1, 32'h0020_9463, 32'h100, 1, 0);
        drive(1, 32'h0020_9463, 32'h100, 1, 0);
        rst = 1'b1;
        #1;
        check("reset_out_instr", out_instr, 32'h0000_0013);
        check("reset_out_pc", out_pc, 32'h0);
        check("reset_branch", branch, 6'b000000);
        check("reset_out_valid", out_valid, 1'b0);

        // BNE, then back-to-back BEQ -> ADD at full throughput.
        drive(1, 32'h0020_9463, 32'h100, 1, 0);
        drive(1, 32'h0020_8463, 32'h104, 1, 0);
        drive(1, 32'h0020_81B3, 32'h108, 1, 0);
        // Remaining opcode classes and all branch types.
        drive(1, 32'h1234_52B7, 32'h10C, 1, 0);
        drive(1, 32'h0000_1297, 32'h110, 1, 0);
        drive(1, 32'h0080_00EF, 32'h114, 1, 0);
        drive(1, 32'h0000_80E7, 32'h118, 1, 0);
        drive(1, 32'h0020_A023, 32'h11C, 1, 0);
        drive(1, 32'h0010_8093, 32'h120, 1, 0);
        drive(1, 32'h0000_C183, 32'h124, 1, 0);
        drive(1, 32'h0020_C463, 32'h128, 1, 0);
        drive(1, 32'h0020_D463, 32'h12C, 1, 0);
        drive(1, 32'h0020_E463, 32'h130, 1, 0);
        drive(1, 32'h0020_F463, 32'h134, 1, 0);
        // Illegal encodings and SYSTEM/MISC-MEM.
        drive(1, 32'h0000_207F, 32'h138, 1, 0);
        drive(1, 32'h0020_A463, 32'h13C, 1, 0);
        drive(1, 32'h0000_B183, 32'h140, 1, 0);
        drive(1, 32'h0000_3023, 32'h144, 1, 0);
        drive(1, 32'h0000_1067, 32'h148, 1, 0);
        drive(1, 32'h0000_0011, 32'h14C, 1, 0);
        drive(1, 32'h0000_0073, 32'h150, 1, 0);
        drive(1, 32'h0000_000F, 32'h154, 1, 0);
        drive(0, 32'h0000_0013, 32'h158, 1, 0);
        drive(0, 32'h0000_0013, 32'h158, 1, 0);

        // Stall: LW held three cycles while ADDI waits, then both move.
        drive(1, 32'h0000_A183, 32'h200, 1, 0);
        drive(1, 32'h0010_8093, 32'h204, 0, 0);
        drive(1, 32'h0010_8093, 32'h204, 0, 0);
        drive(1, 32'h0010_8093, 32'h204, 0, 0);
        drive(1, 32'h0010_8093, 32'h204, 1, 0);
        drive(0, 32'h0010_8093, 32'h204, 1, 0);

        // Flush while stalled with a new instruction offered.
        drive(1, 32'h0000_A183, 32'h300, 1, 0);
        drive(1, 32'h0020_81B3, 32'h304, 0, 1);
        drive(0, 32'h0000_0013, 32'h308, 1, 0);
        drive(1, 32'h0000_1297, 32'h30C, 1, 0);
        drive(0, 32'h0000_0013, 32'h310, 1, 0);

        // Reset mid-stall drops the held instruction.
        drive(1, 32'h0000_A183, 32'h400, 1, 0);
        drive(1, 32'h0020_9463, 32'h404, 0, 0);
        rst = 1'b0;
        drive(1, 32'h0020_9463, 32'h404, 0, 0);
        rst = 1'b1;
        drive(0, 32'h0000_0013, 32'h408, 1, 0);
        drive(0, 32'h0000_0013, 32'h408, 1, 0);

        check("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
